// File: rtl/instruction_fetch_unit.sv
// Multicycle instruction fetch sequencer: issues one memory read per accepted
// fetch_start and delivers the word to the instruction register or reports a fault.
module instruction_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [31:0] pc_in,
  input  logic        abort,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic [31:0] instr_data,
  output logic        ir_write,
  output logic [31:0] old_pc,
  output logic        fetch_done,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       accept;
  logic       timed_out;
  logic       misaligned;

  assign accept     = (state == S_IDLE) && fetch_start && !abort;
  assign misaligned = (pc_in[1:0] != 2'b00);
  // cnt holds (cycle number - 1) while in REQ/WAIT/DRAIN
  assign timed_out  = (cnt >= CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = misaligned ? S_FAULT : S_REQ;
      S_REQ: begin
        if (mem_ready)      state_nxt = abort ? S_DRAIN : S_WAIT;
        else if (abort)     state_nxt = S_IDLE;
        else if (timed_out) state_nxt = S_FAULT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (abort)        state_nxt = S_IDLE;
          else if (mem_err) state_nxt = S_FAULT;
          else              state_nxt = S_DONE;
        end
        else if (abort)     state_nxt = S_DRAIN;
        else if (timed_out) state_nxt = S_FAULT;
      end
      S_DRAIN: if (mem_rvalid || timed_out) state_nxt = S_IDLE;
      S_DONE:  state_nxt = S_IDLE;
      S_FAULT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req     = (state == S_REQ);
    ir_write    = (state == S_DONE);
    fetch_done  = (state == S_DONE);
    fetch_fault = (state == S_FAULT);
    busy        = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      old_pc      <= '0;
      instr_data  <= '0;
      fault_cause <= '0;
      cnt         <= '0;
    end
    else begin
      if (accept) begin
        old_pc      <= pc_in;
        mem_addr    <= pc_in;
        cnt         <= '0;
        fault_cause <= misaligned ? 2'b01 : 2'b00;
      end
      else if ((state == S_REQ || state == S_WAIT || state == S_DRAIN) && cnt != '1) begin
        cnt <= cnt + 8'd1;
      end

      if (state == S_WAIT && mem_rvalid && !abort && !mem_err)
        instr_data <= mem_rdata;

      // From REQ/WAIT a fault is a bus error only when a response is present
      if (state_nxt == S_FAULT && state != S_IDLE)
        fault_cause <= (state == S_WAIT && mem_rvalid) ? 2'b10 : 2'b11;
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch sequencer that reads one 32-bit instruction word from instruction memory and delivers it to the instruction register. It drives the instruction data and the one-cycle `ir_write` strobe. It is started by the multicycle control FSM with `fetch_start` and reports completion or a fault. It also latches the fetch PC as `old_pc` for branch and JAL target calculation in later cycles.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles in REQ+WAIT before a timeout fault. Range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_start` in 1: single-cycle request from the control FSM. Sampled only in IDLE.
- `pc_in` in 32: fetch address, sampled with an accepted `fetch_start`.
- `abort` in 1: cancels the fetch in flight (pipeline flush or trap).
- `mem_req` out 1: read request valid.
- `mem_addr` out 32: read address, stable while `mem_req`=1.
- `mem_ready` in 1: memory accepts the request (handshake completes when `mem_req`&&`mem_ready`).
- `mem_rvalid` in 1: read response valid.
- `mem_rdata` in 32: read data, qualified by `mem_rvalid`.
- `mem_err` in 1: bus error, qualified by `mem_rvalid`.
- `instr_data` out 32: instruction word to the instruction register.
- `ir_write` out 1: one-cycle load strobe to the instruction register.
- `old_pc` out 32: PC of the most recently accepted fetch.
- `fetch_done` out 1: one-cycle pulse, coincident with `ir_write`.
- `fetch_fault` out 1: one-cycle fault pulse.
- `fault_cause` out 2: 00 none, 01 misaligned, 10 bus error, 11 timeout.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, REQ, WAIT, DRAIN, DONE, FAULT.
- **Reset values:** state=IDLE. `mem_req`=0, `mem_addr`=0, `instr_data`=0, `ir_write`=0, `old_pc`=0, `fetch_done`=0, `fetch_fault`=0, `fault_cause`=00, `busy`=0, timeout counter=0.
- **IDLE**
  - `fetch_start`=1 and `abort`=0: latch `pc_in` into `old_pc` and `mem_addr`, clear `fault_cause` to 00, clear the counter.
  - If `pc_in[1:0]`≠00, go to FAULT with cause 01. Otherwise go to REQ.
  - `abort`=1 has priority: `fetch_start` is ignored.
- **REQ:** `mem_req`=1.
  - `mem_ready`=1: go to WAIT, or to DRAIN if `abort`=1 in the same cycle.
  - `abort`=1 with `mem_ready`=0: go to IDLE, with no memory transaction.
- **WAIT:** `mem_req`=0.
  - `mem_rvalid`=1, `mem_err`=0, `abort`=0: register `mem_rdata` into `instr_data` and go to DONE.
  - `mem_rvalid`=1, `mem_err`=1, `abort`=0: go to FAULT with cause 10.
  - `mem_rvalid`=1 with `abort`=1: discard the response and go to IDLE.
  - `abort`=1 with `mem_rvalid`=0: go to DRAIN.
- **DRAIN:** waits for the outstanding response, discards it (data and error), then goes to IDLE. No `ir_write`, no fault.
- **DONE:** `ir_write`=1 and `fetch_done`=1 for exactly this cycle, then IDLE. `abort` in DONE has no effect.
- **FAULT:** `fetch_fault`=1 for exactly this cycle, then IDLE.
- **Timeout:** the counter increments every cycle in REQ, WAIT and DRAIN, saturating at 255.
  - In REQ or WAIT, if cycle number `TIMEOUT_CYCLES` ends without the terminating event (`mem_ready` in REQ, `mem_rvalid` in WAIT), go to FAULT with cause 11. The first REQ cycle is cycle 1.
  - In DRAIN, a timeout returns to IDLE silently.
- **Held outputs:**
  - `instr_data` holds its value until the next successful fetch. It is not modified on fault or abort.
  - `old_pc` and `fault_cause` hold until the next accepted `fetch_start`.
- **Ignored inputs:** `fetch_start` outside IDLE is ignored. `mem_rvalid` in IDLE, REQ, DONE or FAULT is ignored. Only one request is ever outstanding.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- **Minimum latency:** `fetch_start` sampled at edge 0, then `mem_req` high in cycle 1.
  - `mem_ready`=1 in cycle 1 and `mem_rvalid`=1 in cycle 2 give `ir_write`/`fetch_done` in cycle 3.
  - IDLE is re-entered in cycle 4, so the earliest next `fetch_start` is accepted at the end of cycle 4.
- `mem_rvalid` may arrive no earlier than the cycle after the accepting `mem_ready`.
- **Misaligned PC:** `fetch_fault` is high in cycle 1, with `mem_req` never asserted.
- `instr_data` is valid on the same cycle `ir_write` is high. The instruction register captures it at the end of that cycle.
- **Asynchronous reset:** forces IDLE and all reset values immediately, including mid-transaction. Any later `mem_rvalid` is ignored because the block is in IDLE.

## Test plan
- **Aligned fetch:** `pc_in`=0x0000_0040, `mem_ready` in cycle 1, `mem_rvalid` with `mem_rdata`=0x0050_0093 in cycle 2.
  - Expect `ir_write`=`fetch_done`=1 in cycle 3 only, `instr_data`=0x0050_0093, `old_pc`=0x40, `fault_cause`=00.
- **Stalled memory:** `mem_ready` is low for 3 cycles and `mem_rvalid` arrives 4 cycles after accept.
  - Expect `mem_addr` stable through REQ and `ir_write` exactly once.
  - Expect a `fetch_start` pulsed while busy to be ignored.
- **Misaligned and bus error:**
  - `pc_in`=0x0000_0042: expect `fetch_fault` in cycle 1, cause 01, no `mem_req`.
  - Response with `mem_err`=1: expect `fetch_fault` the cycle after `mem_rvalid`, cause 10, `instr_data` unchanged.
- **Timeout:** `TIMEOUT_CYCLES`=16 and `mem_ready` held low.
  - Expect `fetch_fault` with cause 11 in cycle 17.
  - Expect `mem_req` high for cycles 1–16 only.
- **Abort:**
  - Abort in REQ without `mem_ready`: expect IDLE next cycle.
  - Abort in WAIT: expect the DRAIN response (0xDEAD_BEEF) discarded, no `ir_write`, `instr_data` unchanged.
  - Abort coincident with `mem_ready`: expect DRAIN.
- **Reset mid-fetch:** assert `rst` in WAIT.
  - Expect all outputs at reset values immediately, with no `ir_write` when the late `mem_rvalid` arrives.
  - A new fetch then completes normally.
